// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM states and bus park values for lsu_initiator
package lsu_pkg;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b011;
    localparam logic [2:0] SZ_WORD = 3'b111;

    localparam int SM_SIGN_BIT = 3;
    localparam int SM_SIZE_HI  = 2;
    localparam int SM_SIZE_LO  = 0;

    localparam logic [31:0] PARK_ADDR      = 32'h0000_0000;
    localparam logic [31:0] PARK_WDATA     = 32'h0000_0000;
    localparam logic [3:0]  PARK_SIGN_MASK = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic size_legal(input logic [2:0] sz);
        return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] sz, input logic [1:0] a);
        return ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_initiator_stall_watchdog.sv
// rtl/lsu_initiator_stall_watchdog.sv - per-state cycle counter that flags a hung stall handshake
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import lsu_pkg::*;

    localparam int W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(STALL_TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;
    logic         expired_q, expired_d;

    // The flag is registered so the FSM never sees a combinational path from the counter.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (clear) begin
            cnt_d     = '0;
            expired_d = 1'b0;
        end else if (enable) begin
            expired_d = (cnt_q == LIMIT);
            if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/lsu_initiator.sv
// rtl/lsu_initiator.sv - MEM-stage request to data-memory stall handshake initiator
// Optional alignment rejection is built when LSU_MISALIGN_CHECK_EN is defined.
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter int STALL_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sign_mask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    output logic        memread,
    output logic        memwrite,
    output logic [3:0]  sign_mask,
    input  logic [31:0] read_data,
    input  logic        clk_stall
);

    lsu_state_e state_q, state_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sm_q, sm_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        pend_q, pend_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_bad;
    logic        wd_expired;
    logic        wd_clear;
    logic        wd_enable;

    always_comb begin
        req_bad = !size_legal(req_sign_mask[SM_SIZE_HI:SM_SIZE_LO]);
`ifdef LSU_MISALIGN_CHECK_EN
        if (addr_misaligned(req_sign_mask[SM_SIZE_HI:SM_SIZE_LO], req_addr[1:0])) begin
            req_bad = 1'b1;
        end
`endif
    end

    assign wd_clear  = (state_d != state_q);
    assign wd_enable = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = req_bad ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wd_expired) begin
                    state_d = ST_RESP;
                end else if (clk_stall) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wd_expired || !clk_stall) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // A rejected request spends one extra RESP cycle before its error pulse.
                state_d = pend_q ? ST_RESP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sm_d         = sm_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        pend_d       = pend_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        pend_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        sm_d    = req_sign_mask;
                        rd_d    = !req_write;
                        wr_d    = req_write;
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (state_d == ST_RESP) begin
                    addr_d       = PARK_ADDR;
                    wdata_d      = PARK_WDATA;
                    sm_d         = PARK_SIGN_MASK;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = wd_expired;
                    rdata_d      = ((state_q == ST_WAIT) && !wd_expired && rd_q) ? read_data : 32'h0;
                end
            end
            ST_RESP: begin
                if (pend_q) begin
                    pend_d       = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    rdata_d      = 32'h0;
                end
            end
            default: begin
                pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= PARK_ADDR;
            wdata_q      <= PARK_WDATA;
            sm_q         <= PARK_SIGN_MASK;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            pend_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sm_q         <= sm_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            pend_q       <= pend_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rdata_q;
    assign addr       = addr_q;
    assign write_data = wdata_q;
    assign sign_mask  = sm_q;
    assign memread    = rd_q;
    assign memwrite   = wr_q;

endmodule
